// File: rtl/sha256_msg_padder.sv
// sha256_msg_padder: absorbs a byte stream, applies FIPS 180-4 padding and emits 512-bit blocks.
// Optional feature macro SHA_PAD_BLKCNT_EN adds blk_cnt, the number of blocks emitted for the current message.
module sha256_msg_padder #(
    parameter int LEN_W     = 64,
    parameter int START_CYC = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [7:0]   din,
    input  logic         din_valid,
    input  logic         din_last,
    input  logic         din_empty,
    output logic         din_ready,
    output logic [511:0] M,
    output logic         start,
    output logic         blk_last,
    input  logic         blk_ack,
`ifdef SHA_PAD_BLKCNT_EN
    output logic [15:0]  blk_cnt,
`endif
    output logic         busy
);

    typedef enum logic [2:0] {IDLE, ABSORB, PAD80, PADZ, PADLEN, EMIT, WAIT_ACK} state_t;

    localparam logic [1:0] CYC_END = 2'(START_CYC - 1);

    state_t             state_q, state_d, res_q, res_d;
    logic [5:0]         idx_q, idx_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [511:0]       m_q, m_d;
    logic               last_q, last_d;
    logic [1:0]         cyc_q, cyc_d;
    logic               rdy_q;
    logic               xfer, wr;
    logic [7:0]         wbyte;

    assign xfer      = din_valid && rdy_q;
    assign din_ready = rdy_q;
    assign M         = m_q;
    assign blk_last  = last_q;
    assign start     = state_q == EMIT;
    assign busy      = state_q != IDLE;

    // Next-state logic: one byte (data or padding) is written per cycle at the running index.
    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        idx_d   = idx_q;
        len_d   = len_q;
        m_d     = m_q;
        last_d  = last_q;
        cyc_d   = cyc_q;
        wr      = 1'b0;
        wbyte   = 8'h00;
        case (state_q)
            IDLE: begin
                if (xfer) begin
                    wr      = 1'b1;
                    wbyte   = din;
                    len_d   = len_q + LEN_W'(8);
                    state_d = din_last ? PAD80 : ABSORB;
                end else if (din_empty) begin
                    state_d = PAD80;
                end
            end
            ABSORB: begin
                if (xfer) begin
                    wr    = 1'b1;
                    wbyte = din;
                    len_d = len_q + LEN_W'(8);
                    if (idx_q == 6'd63) begin
                        state_d = EMIT;
                        res_d   = din_last ? PAD80 : ABSORB;
                    end else if (din_last) begin
                        state_d = PAD80;
                    end
                end
            end
            PAD80: begin
                wr    = 1'b1;
                wbyte = 8'h80;
                if (idx_q == 6'd63) begin
                    state_d = EMIT;
                    res_d   = PADZ;
                end else begin
                    state_d = (idx_q == 6'd55) ? PADLEN : PADZ;
                end
            end
            PADZ: begin
                wr = 1'b1;
                if (idx_q == 6'd55) begin
                    state_d = PADLEN;
                end else if (idx_q == 6'd63) begin
                    state_d = EMIT;
                    res_d   = PADZ;
                end
            end
            PADLEN: begin
                wr    = 1'b1;
                wbyte = 8'(len_q >> {~idx_q[2:0], 3'b000});
                if (idx_q == 6'd63) begin
                    state_d = EMIT;
                    res_d   = IDLE;
                    last_d  = 1'b1;
                end
            end
            EMIT: begin
                if (cyc_q == CYC_END) begin
                    cyc_d   = 2'd0;
                    state_d = WAIT_ACK;
                end else begin
                    cyc_d = cyc_q + 2'd1;
                end
            end
            WAIT_ACK: begin
                if (blk_ack) begin
                    idx_d   = 6'd0;
                    state_d = last_q ? IDLE : res_q;
                    if (last_q) begin
                        len_d  = '0;
                        last_d = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (wr) begin
            m_d[{~idx_q, 3'b111} -: 8] = wbyte;
            idx_d = idx_q + 6'd1;
        end
    end

    // State register; din_ready is registered from the next state so it is low during reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            res_q   <= IDLE;
            idx_q   <= '0;
            len_q   <= '0;
            m_q     <= '0;
            last_q  <= 1'b0;
            cyc_q   <= '0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            m_q     <= m_d;
            last_q  <= last_d;
            cyc_q   <= cyc_d;
            rdy_q   <= state_d == IDLE || state_d == ABSORB;
        end
    end

`ifdef SHA_PAD_BLKCNT_EN
    logic [15:0] cnt_q;

    // Count start pulses per message, saturating; a new message in IDLE restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (state_q == IDLE && (xfer || din_empty)) begin
            cnt_q <= '0;
        end else if (state_d == EMIT && state_q != EMIT && cnt_q != 16'hFFFF) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign blk_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_sha256_msg_padder.sv
// tb_sha256_msg_padder: directed padding vectors with hand-computed blocks, latencies and handshakes.
module tb_sha256_msg_padder;

    localparam int START_CYC = 1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [7:0]   din;
    logic         din_valid, din_last, din_empty, din_ready;
    logic [511:0] M;
    logic         start, blk_last, blk_ack, busy;
`ifdef SHA_PAD_BLKCNT_EN
    logic [15:0]  blk_cnt;
`endif

    int errs = 0;
    int checks = 0;

    sha256_msg_padder #(.LEN_W(64), .START_CYC(START_CYC)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .din(din),
        .din_valid(din_valid),
        .din_last(din_last),
        .din_empty(din_empty),
        .din_ready(din_ready),
        .M(M),
        .start(start),
        .blk_last(blk_last),
        .blk_ack(blk_ack),
`ifdef SHA_PAD_BLKCNT_EN
        .blk_cnt(blk_cnt),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input logic last);
        int n = 0;
        din       = b;
        din_valid = 1'b1;
        din_last  = last;
        while (!din_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("send timeout", 512'(n), 512'(0));
        @(negedge clk);
        din_valid = 1'b0;
        din_last  = 1'b0;
    endtask

    task automatic send_n(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) send(b, i == n - 1);
    endtask

    task automatic wait_start(input string tag, input int exp_w);
        int w = 0;
        logic rdy = 1'b0;
        while (!start && w < 300) begin
            rdy |= din_ready;
            @(negedge clk);
            w++;
        end
        chk({tag, " latency"}, 512'(w), 512'(exp_w));
        chk({tag, " ready while padding"}, 512'(rdy), 512'(1'b0));
    endtask

    task automatic check_block(input string tag, input logic [511:0] exp_m, input logic exp_last);
        logic [511:0] held;
        chk({tag, " M"}, M, exp_m);
        chk({tag, " blk_last"}, 512'(blk_last), 512'(exp_last));
        chk({tag, " start"}, 512'(start), 512'(1'b1));
        chk({tag, " din_ready"}, 512'(din_ready), 512'(1'b0));
        held = M;
        repeat (START_CYC) @(negedge clk);
        chk({tag, " start low"}, 512'(start), 512'(1'b0));
        chk({tag, " M held"}, M, held);
    endtask

    task automatic ack();
        blk_ack = 1'b1;
        @(negedge clk);
        blk_ack = 1'b0;
    endtask

    task automatic check_done(input string tag);
        chk({tag, " busy after ack"}, 512'(busy), 512'(1'b0));
        chk({tag, " ready after ack"}, 512'(din_ready), 512'(1'b1));
        chk({tag, " blk_last cleared"}, 512'(blk_last), 512'(1'b0));
    endtask

    task automatic run_abc(input string tag);
        send(8'h61, 1'b0);
        send(8'h62, 1'b0);
        send(8'h63, 1'b1);
        wait_start(tag, 61);
        check_block(tag, {32'h61626380, 416'h0, 64'h18}, 1'b1);
        ack();
        check_done(tag);
    endtask

    initial begin
        logic [511:0] held;
        logic bad;
        din       = 8'h00;
        din_valid = 1'b0;
        din_last  = 1'b0;
        din_empty = 1'b0;
        blk_ack   = 1'b0;
        @(negedge clk);
        chk("reset M", M, '0);
        chk("reset start", 512'(start), 512'(1'b0));
        chk("reset blk_last", 512'(blk_last), 512'(1'b0));
        chk("reset din_ready", 512'(din_ready), 512'(1'b0));
        chk("reset busy", 512'(busy), 512'(1'b0));
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("idle ready", 512'(din_ready), 512'(1'b1));
        blk_ack = 1'b1;
        @(negedge clk);
        blk_ack = 1'b0;
        chk("ack in idle ignored", 512'(busy), 512'(1'b0));

        run_abc("abc");

        send_n(8'h00, 55);
        wait_start("z55", 9);
        check_block("z55", {440'h0, 8'h80, 64'h1B8}, 1'b0 == 1'b1 ? 1'b0 : 1'b1);
        ack();
        check_done("z55");

        send_n(8'h00, 56);
        wait_start("z56 b1", 8);
        check_block("z56 b1", {448'h0, 8'h80, 56'h0}, 1'b0);
        held      = M;
        bad       = 1'b0;
        din       = 8'hAA;
        din_valid = 1'b1;
        repeat (50) begin
            @(negedge clk);
            bad |= (M !== held) || start || din_ready || blk_last || !busy;
        end
        din_valid = 1'b0;
        chk("hold stable", 512'(bad), 512'(1'b0));
        ack();
        wait_start("z56 b2", 64);
        check_block("z56 b2", {448'h0, 64'h1C0}, 1'b1);
`ifdef SHA_PAD_BLKCNT_EN
        chk("z56 blk_cnt", 512'(blk_cnt), 512'(2));
`endif
        ack();
        check_done("z56");

        send_n(8'hFF, 64);
        wait_start("ff b1", 0);
        check_block("ff b1", {512{1'b1}}, 1'b0);
        ack();
        wait_start("ff b2", 64);
        check_block("ff b2", {8'h80, 440'h0, 64'h200}, 1'b1);
        ack();
        check_done("ff");

        din_empty = 1'b1;
        @(negedge clk);
        din_empty = 1'b0;
        wait_start("empty", 64);
        check_block("empty", {8'h80, 504'h0}, 1'b1);
        ack();
        check_done("empty");

        for (int i = 0; i < 20; i++) send(8'h5A, 1'b0);
        chk("busy mid message", 512'(busy), 512'(1'b1));
        rst_n = 1'b0;
        #1;
        chk("abort M", M, '0);
        chk("abort start", 512'(start), 512'(1'b0));
        chk("abort blk_last", 512'(blk_last), 512'(1'b0));
        chk("abort din_ready", 512'(din_ready), 512'(1'b0));
        chk("abort busy", 512'(busy), 512'(1'b0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        run_abc("abc after reset");

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
